// File: rtl/obuf_drain.sv
// Output-buffer drain: after a MAC pass, reads each 64-bit word of the result
// buffer, unpacks its valid 16-bit elements and streams them row-major to the host.
module obuf_drain #(
    parameter bit CLEAR_AFTER_READ = 1'b0,
    parameter int ELEM_W           = 16
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic [11:0]         MNT,
    input  logic                START,
    output logic                EN_O,
    output logic                RW_O,
    output logic [3:0]          ADDR_O,
    output logic [4*ELEM_W-1:0] WDATA_O,
    input  logic [4*ELEM_W-1:0] RDATA_O,
    output logic [ELEM_W-1:0]   DOUT,
    output logic                DOUT_VALID,
    input  logic                DOUT_READY,
    output logic [2:0]          DOUT_ROW,
    output logic [2:0]          DOUT_COL,
    output logic                DOUT_LAST,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);
    localparam int WORD_W = 4 * ELEM_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_CAP = 3'd2,
        CLR    = 3'd3,
        EMIT   = 3'd4,
        FIN    = 3'd5
    } state_t;

    // Element 0 sits in the most significant slice of the word.
    function automatic logic [ELEM_W-1:0] pick_elem(input logic [WORD_W-1:0] word,
                                                     input logic [1:0] idx);
        logic [ELEM_W-1:0] e;
        case (idx)
            2'd0:    e = word[4*ELEM_W-1 -: ELEM_W];
            2'd1:    e = word[3*ELEM_W-1 -: ELEM_W];
            2'd2:    e = word[2*ELEM_W-1 -: ELEM_W];
            default: e = word[ELEM_W-1:0];
        endcase
        return e;
    endfunction

    function automatic logic [2:0] elems_in_word(input logic [3:0] t, input logic w);
        logic [3:0] rem;
        logic [2:0] n;
        rem = t - 4'd4;
        if (w) begin
            n = rem[2:0];
        end else if (t > 4'd4) begin
            n = 3'd4;
        end else begin
            n = t[2:0];
        end
        return n;
    endfunction

    function automatic logic [3:0] word_addr(input logic [2:0] row, input logic w,
                                             input logic two_per_row);
        logic [3:0] a;
        if (two_per_row) begin
            a = {row, w};
        end else begin
            a = {1'b0, row};
        end
        return a;
    endfunction

    function automatic logic mnt_legal(input logic [11:0] mnt);
        logic [3:0] m;
        logic [3:0] t;
        m = mnt[11:8];
        t = mnt[3:0];
        return (m != 4'd0) && (m <= 4'd8) && (t != 4'd0) && (t <= 4'd8);
    endfunction

    function automatic logic is_last_pos(input logic [2:0] row, input logic [2:0] col,
                                         input logic [3:0] m, input logic [3:0] t);
        return ({1'b0, row} == (m - 4'd1)) && ({1'b0, col} == (t - 4'd1));
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          m_q, m_d;
    logic [3:0]          t_q, t_d;
    logic [2:0]          row_q, row_d;
    logic                w_q, w_d;
    logic [1:0]          elem_q, elem_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                en_q, en_d;
    logic                rw_q, rw_d;
    logic [3:0]          addr_q, addr_d;
    logic [ELEM_W-1:0]   dout_q, dout_d;
    logic                valid_q, valid_d;
    logic [2:0]          orow_q, orow_d;
    logic [2:0]          col_q, col_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                wpr2_s;
    logic [2:0]          n_elem_s;
    logic                last_word_s;
    logic                word_end_s;
    logic [2:0]          nxt_row_s;
    logic                nxt_w_s;
    logic [2:0]          first_col_s;
    logic [1:0]          nxt_idx_s;
    logic [2:0]          nxt_col_s;
    logic                mnt_n_unused_s;

    assign mnt_n_unused_s = ^MNT[7:4];

    // Geometry of the word currently being walked and the position that follows it.
    always_comb begin
        wpr2_s      = (t_q > 4'd4);
        n_elem_s    = elems_in_word(t_q, w_q);
        last_word_s = ({1'b0, row_q} == (m_q - 4'd1)) && (w_q == wpr2_s);
        word_end_s  = ({1'b0, elem_q} == (n_elem_s - 3'd1));
        first_col_s = {w_q, 2'b00};
        nxt_idx_s   = elem_q + 2'd1;
        nxt_col_s   = col_q + 3'd1;
        if (w_q || !wpr2_s) begin
            nxt_w_s   = 1'b0;
            nxt_row_s = row_q + 3'd1;
        end else begin
            nxt_w_s   = 1'b1;
            nxt_row_s = row_q;
        end
    end

    // Next-state and registered-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        t_d     = t_q;
        row_d   = row_q;
        w_d     = w_q;
        elem_d  = elem_q;
        hold_d  = hold_q;
        en_d    = 1'b1;
        rw_d    = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        orow_d  = orow_q;
        col_d   = col_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    if (mnt_legal(MNT)) begin
                        m_d     = MNT[11:8];
                        t_d     = MNT[3:0];
                        row_d   = 3'd0;
                        w_d     = 1'b0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        en_d    = 1'b0;
                        addr_d  = 4'd0;
                        state_d = RD_REQ;
                    end else begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FIN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                hold_d = RDATA_O;
                if (CLEAR_AFTER_READ) begin
                    en_d    = 1'b0;
                    rw_d    = 1'b1;
                    state_d = CLR;
                end else begin
                    // Present element 0 straight from the bus so it appears one cycle earlier.
                    elem_d  = 2'd0;
                    dout_d  = pick_elem(RDATA_O, 2'd0);
                    valid_d = 1'b1;
                    orow_d  = row_q;
                    col_d   = first_col_s;
                    last_d  = is_last_pos(row_q, first_col_s, m_q, t_q);
                    state_d = EMIT;
                end
            end
            CLR: begin
                elem_d  = 2'd0;
                dout_d  = pick_elem(hold_q, 2'd0);
                valid_d = 1'b1;
                orow_d  = row_q;
                col_d   = first_col_s;
                last_d  = is_last_pos(row_q, first_col_s, m_q, t_q);
                state_d = EMIT;
            end
            EMIT: begin
                if (DOUT_READY) begin
                    if (word_end_s) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (last_word_s) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = FIN;
                        end else begin
                            row_d   = nxt_row_s;
                            w_d     = nxt_w_s;
                            en_d    = 1'b0;
                            addr_d  = word_addr(nxt_row_s, nxt_w_s, wpr2_s);
                            state_d = RD_REQ;
                        end
                    end else begin
                        elem_d = nxt_idx_s;
                        dout_d = pick_elem(hold_q, nxt_idx_s);
                        col_d  = nxt_col_s;
                        last_d = is_last_pos(row_q, nxt_col_s, m_q, t_q);
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            FIN: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; the buffer enable idles high (deselected).
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            m_q     <= 4'd0;
            t_q     <= 4'd0;
            row_q   <= 3'd0;
            w_q     <= 1'b0;
            elem_q  <= 2'd0;
            hold_q  <= {WORD_W{1'b0}};
            en_q    <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= 4'd0;
            dout_q  <= {ELEM_W{1'b0}};
            valid_q <= 1'b0;
            orow_q  <= 3'd0;
            col_q   <= 3'd0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            t_q     <= t_d;
            row_q   <= row_d;
            w_q     <= w_d;
            elem_q  <= elem_d;
            hold_q  <= hold_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            orow_q  <= orow_d;
            col_q   <= col_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign EN_O       = en_q;
    assign RW_O       = rw_q;
    assign ADDR_O     = addr_q;
    assign WDATA_O    = {WORD_W{1'b0}};
    assign DOUT       = dout_q;
    assign DOUT_VALID = valid_q;
    assign DOUT_ROW   = orow_q;
    assign DOUT_COL   = col_q;
    assign DOUT_LAST  = last_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_obuf_drain.sv
// Directed bench for obuf_drain: two instances (no clear / clear-after-read), each
// with its own behavioural output-buffer memory.
module tb_obuf_drain;
    logic        CLK;
    logic        RSTN;
    logic [11:0] mnt_s   [2];
    logic        start_s [2];
    logic        en_s    [2];
    logic        rw_s    [2];
    logic [3:0]  addr_s  [2];
    logic [63:0] wdata_s [2];
    logic [63:0] rdata_s [2];
    logic [15:0] dout_s  [2];
    logic        valid_s [2];
    logic        ready_s [2];
    logic [2:0]  row_s   [2];
    logic [2:0]  col_s   [2];
    logic        last_s  [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        err_s   [2];

    logic [63:0] mem      [2][16];
    logic        pre_we   [2];
    logic [3:0]  pre_addr [2];
    logic [63:0] pre_data [2];

    int n_vec;
    int n_fail;

    logic [15:0] g_dout [$];
    logic [2:0]  g_row  [$];
    logic [2:0]  g_col  [$];
    logic        g_last [$];
    logic [4:0]  g_ops  [$];
    int          first_valid, done_cyc, stall_bad, wbad;
    logic        busy1;

    obuf_drain #(.CLEAR_AFTER_READ(1'b0), .ELEM_W(16)) u_dut0 (
        .CLK(CLK), .RSTN(RSTN), .MNT(mnt_s[0]), .START(start_s[0]),
        .EN_O(en_s[0]), .RW_O(rw_s[0]), .ADDR_O(addr_s[0]), .WDATA_O(wdata_s[0]),
        .RDATA_O(rdata_s[0]), .DOUT(dout_s[0]), .DOUT_VALID(valid_s[0]),
        .DOUT_READY(ready_s[0]), .DOUT_ROW(row_s[0]), .DOUT_COL(col_s[0]),
        .DOUT_LAST(last_s[0]), .BUSY(busy_s[0]), .DONE(done_s[0]), .ERR(err_s[0])
    );

    obuf_drain #(.CLEAR_AFTER_READ(1'b1), .ELEM_W(16)) u_dut1 (
        .CLK(CLK), .RSTN(RSTN), .MNT(mnt_s[1]), .START(start_s[1]),
        .EN_O(en_s[1]), .RW_O(rw_s[1]), .ADDR_O(addr_s[1]), .WDATA_O(wdata_s[1]),
        .RDATA_O(rdata_s[1]), .DOUT(dout_s[1]), .DOUT_VALID(valid_s[1]),
        .DOUT_READY(ready_s[1]), .DOUT_ROW(row_s[1]), .DOUT_COL(col_s[1]),
        .DOUT_LAST(last_s[1]), .BUSY(busy_s[1]), .DONE(done_s[1]), .ERR(err_s[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous buffer: read data appears the cycle after the request.
    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (pre_we[k]) begin
                mem[k][pre_addr[k]] <= pre_data[k];
            end else if (!en_s[k]) begin
                if (rw_s[k]) mem[k][addr_s[k]] <= wdata_s[k];
                else         rdata_s[k] <= mem[k][addr_s[k]];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic load(input int d, input logic [3:0] a, input logic [63:0] data);
        @(negedge CLK);
        pre_we[d]   = 1'b1;
        pre_addr[d] = a;
        pre_data[d] = data;
        @(negedge CLK);
        pre_we[d]   = 1'b0;
    endtask

    // Runs one drain, recording buffer accesses, accepted elements and stall stability.
    task automatic drain(input int d, input logic [11:0] mnt, input logic [3:0] rpat,
                         input int restart_cyc, input logic [11:0] alt_mnt);
        logic        stalled;
        logic [15:0] pd;
        logic [2:0]  prow, pcol;
        logic        plast, r;
        g_dout.delete(); g_row.delete(); g_col.delete(); g_last.delete(); g_ops.delete();
        first_valid = -1; done_cyc = -1; stall_bad = 0; wbad = 0; busy1 = 1'b0;
        stalled = 1'b0; pd = 16'h0; prow = 3'd0; pcol = 3'd0; plast = 1'b0;
        @(negedge CLK);
        mnt_s[d]   = mnt;
        start_s[d] = 1'b1;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(negedge CLK);
            start_s[d] = (cyc == restart_cyc);
            if (cyc == restart_cyc) mnt_s[d] = alt_mnt;
            if (cyc == 1) busy1 = busy_s[d];
            if (!en_s[d]) begin
                g_ops.push_back({rw_s[d], addr_s[d]});
                if (rw_s[d] && wdata_s[d] !== 64'h0) wbad++;
            end
            if (valid_s[d] && first_valid < 0) first_valid = cyc;
            if (stalled && (!valid_s[d] || dout_s[d] !== pd || row_s[d] !== prow ||
                            col_s[d] !== pcol || last_s[d] !== plast)) stall_bad++;
            r = rpat[cyc % 4];
            ready_s[d] = r;
            if (valid_s[d] && r) begin
                g_dout.push_back(dout_s[d]);
                g_row.push_back(row_s[d]);
                g_col.push_back(col_s[d]);
                g_last.push_back(last_s[d]);
            end
            stalled = valid_s[d] && !r;
            pd = dout_s[d]; prow = row_s[d]; pcol = col_s[d]; plast = last_s[d];
            if (done_s[d]) begin
                done_cyc = cyc;
                break;
            end
        end
        start_s[d] = 1'b0;
        ready_s[d] = 1'b1;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({en_s[0], rw_s[0], addr_s[0], valid_s[0], row_s[0], col_s[0], last_s[0]} !== 14'b1_0_0000_0_000_000_0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got en=%b rw=%b addr=%h v=%b row=%0d col=%0d last=%b expected 1 0 0 0 0 0 0",
                     en_s[0], rw_s[0], addr_s[0], valid_s[0], row_s[0], col_s[0], last_s[0]);
        end
        n_vec++;
        if (dout_s[0] !== 16'h0 || wdata_s[0] !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got dout=%h wdata=%h expected 0 0", dout_s[0], wdata_s[0]);
        end
        n_vec++;
        if ({busy_s[0], done_s[0], err_s[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: got busy/done/err=%b expected 000", {busy_s[0], done_s[0], err_s[0]});
        end
        n_vec++;
        if ({en_s[1], valid_s[1], busy_s[1]} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_dut1: got en/valid/busy=%b expected 100", {en_s[1], valid_s[1], busy_s[1]});
        end
    endtask

    task automatic test_basic();
        load(0, 4'd0, 64'h0001_0002_0003_0004);
        load(0, 4'd1, 64'h0005_0006_0007_0008);
        drain(0, 12'h204, 4'b1111, -1, 12'h000);
        n_vec++;
        if (g_dout.size() != 8) begin n_fail++; $display("FAIL basic_count: got %0d expected 8", g_dout.size()); end
        for (int i = 0; i < g_dout.size(); i++) begin
            n_vec++;
            if ({g_dout[i], g_row[i], g_col[i], g_last[i]} !== {16'(i + 1), 3'(i / 4), 3'(i % 4), (i == 7)}) begin
                n_fail++;
                $display("FAIL basic_elem[%0d]: got %h r%0d c%0d l%b expected %h r%0d c%0d l%b", i,
                         g_dout[i], g_row[i], g_col[i], g_last[i], 16'(i + 1), i / 4, i % 4, (i == 7));
            end
        end
        n_vec++;
        if (g_ops.size() != 2 || g_ops[0] !== 5'h00 || g_ops[1] !== 5'h01) begin
            n_fail++; $display("FAIL basic_reads: got %0d accesses expected reads at 0,1", g_ops.size());
        end
        n_vec++;
        if (first_valid != 3 || done_cyc != 13 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_timing: got valid@%0d done@%0d busy=%b expected 3 13 1", first_valid, done_cyc, busy1);
        end
    endtask

    task automatic test_padding();
        logic [15:0] exp_v [6];
        exp_v = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E, 16'h000F};
        load(0, 4'd0, 64'h000A_000B_000C_000D);
        load(0, 4'd1, 64'h000E_000F_1111_2222);
        drain(0, 12'h106, 4'b1111, -1, 12'h000);
        n_vec++;
        if (g_dout.size() != 6) begin n_fail++; $display("FAIL pad_count: got %0d expected 6", g_dout.size()); end
        for (int i = 0; i < g_dout.size() && i < 6; i++) begin
            n_vec++;
            if ({g_dout[i], g_row[i], g_col[i], g_last[i]} !== {exp_v[i], 3'd0, 3'(i), (i == 5)}) begin
                n_fail++;
                $display("FAIL pad_elem[%0d]: got %h c%0d l%b expected %h c%0d l%b", i,
                         g_dout[i], g_col[i], g_last[i], exp_v[i], i, (i == 5));
            end
        end
        n_vec++;
        if (done_cyc != 11 || g_ops.size() != 2) begin
            n_fail++; $display("FAIL pad_timing: got done@%0d accesses=%0d expected 11 2", done_cyc, g_ops.size());
        end
    endtask

    task automatic test_stall();
        logic [63:0] word;
        int r, c;
        for (int a = 0; a < 16; a++) begin
            word = 64'h0;
            for (int e = 0; e < 4; e++) word = (word << 16) | 64'(16'h1000 + (a / 2) * 256 + (a % 2) * 4 + e);
            load(0, 4'(a), word);
        end
        drain(0, 12'h808, 4'b1001, -1, 12'h000);
        n_vec++;
        if (g_dout.size() != 64) begin n_fail++; $display("FAIL stall_count: got %0d expected 64", g_dout.size()); end
        for (int i = 0; i < g_dout.size(); i++) begin
            r = i / 8;
            c = i % 8;
            n_vec++;
            if ({g_dout[i], g_row[i], g_col[i], g_last[i]} !== {16'(16'h1000 + r * 256 + c), 3'(r), 3'(c), (i == 63)}) begin
                n_fail++;
                $display("FAIL stall_elem[%0d]: got %h r%0d c%0d l%b expected %h r%0d c%0d l%b", i,
                         g_dout[i], g_row[i], g_col[i], g_last[i], 16'(16'h1000 + r * 256 + c), r, c, (i == 63));
            end
        end
        n_vec++;
        if (g_ops.size() != 16) begin n_fail++; $display("FAIL stall_reads: got %0d expected 16", g_ops.size()); end
        for (int i = 0; i < g_ops.size(); i++) begin
            n_vec++;
            if (g_ops[i] !== {1'b0, 4'(i)}) begin
                n_fail++; $display("FAIL stall_addr[%0d]: got %h expected %h", i, g_ops[i], {1'b0, 4'(i)});
            end
        end
        n_vec++;
        if (stall_bad != 0 || done_cyc < 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d unstable stalls done@%0d expected 0 and done", stall_bad, done_cyc);
        end
    endtask

    task automatic test_clear();
        logic [15:0] exp_v [4];
        exp_v = '{16'h1111, 16'h2222, 16'h5555, 16'h6666};
        load(1, 4'd0, 64'h1111_2222_3333_4444);
        load(1, 4'd1, 64'h5555_6666_7777_8888);
        drain(1, 12'h202, 4'b1111, -1, 12'h000);
        n_vec++;
        if (g_ops.size() != 4 || g_ops[0] !== 5'h00 || g_ops[1] !== 5'h10 ||
            g_ops[2] !== 5'h01 || g_ops[3] !== 5'h11 || wbad != 0) begin
            n_fail++; $display("FAIL clr_ops: got %0d accesses wbad=%0d expected rd0 wr0 rd1 wr1 zero data", g_ops.size(), wbad);
        end
        n_vec++;
        if (g_dout.size() != 4) begin n_fail++; $display("FAIL clr_count: got %0d expected 4", g_dout.size()); end
        for (int i = 0; i < g_dout.size() && i < 4; i++) begin
            n_vec++;
            if ({g_dout[i], g_row[i], g_col[i]} !== {exp_v[i], 3'(i / 2), 3'(i % 2)}) begin
                n_fail++; $display("FAIL clr_elem[%0d]: got %h expected %h", i, g_dout[i], exp_v[i]);
            end
        end
        n_vec++;
        if (first_valid != 4 || done_cyc != 11) begin
            n_fail++; $display("FAIL clr_timing: got valid@%0d done@%0d expected 4 11", first_valid, done_cyc);
        end
        drain(1, 12'h202, 4'b1111, -1, 12'h000);
        n_vec++;
        if (g_dout.size() != 4) begin n_fail++; $display("FAIL clr2_count: got %0d expected 4", g_dout.size()); end
        for (int i = 0; i < g_dout.size(); i++) begin
            n_vec++;
            if (g_dout[i] !== 16'h0) begin
                n_fail++; $display("FAIL clr2_zero[%0d]: got %h expected 0000", i, g_dout[i]);
            end
        end
    endtask

    task automatic test_illegal();
        @(negedge CLK);
        mnt_s[0] = 12'h040; start_s[0] = 1'b1;
        @(negedge CLK);
        start_s[0] = 1'b0;
        n_vec++;
        if ({err_s[0], done_s[0], en_s[0], busy_s[0]} !== 4'b1110) begin
            n_fail++; $display("FAIL ill_m0: got err/done/en/busy=%b expected 1110", {err_s[0], done_s[0], en_s[0], busy_s[0]});
        end
        @(negedge CLK);
        n_vec++;
        if ({err_s[0], done_s[0], en_s[0]} !== 3'b101) begin
            n_fail++; $display("FAIL ill_after: got err/done/en=%b expected 101", {err_s[0], done_s[0], en_s[0]});
        end
        mnt_s[0] = 12'h109; start_s[0] = 1'b1;
        @(negedge CLK);
        start_s[0] = 1'b0;
        n_vec++;
        if ({err_s[0], done_s[0], en_s[0]} !== 3'b111) begin
            n_fail++; $display("FAIL ill_t9: got err/done/en=%b expected 111", {err_s[0], done_s[0], en_s[0]});
        end
        load(0, 4'd0, 64'h0001_0002_0003_0004);
        drain(0, 12'h104, 4'b1111, 3, 12'h808);
        n_vec++;
        if (g_dout.size() != 4 || g_ops.size() != 1 || done_cyc != 7 || err_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start: got %0d elems %0d accesses done@%0d err=%b expected 4 1 7 0",
                     g_dout.size(), g_ops.size(), done_cyc, err_s[0]);
        end
        for (int i = 0; i < g_dout.size(); i++) begin
            n_vec++;
            if (g_dout[i] !== 16'(i + 1)) begin
                n_fail++; $display("FAIL busy_elem[%0d]: got %h expected %h", i, g_dout[i], 16'(i + 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        load(0, 4'd0, 64'h0001_0002_0003_0004);
        load(0, 4'd1, 64'h0005_0006_0007_0008);
        @(negedge CLK);
        mnt_s[0] = 12'h204; start_s[0] = 1'b1; ready_s[0] = 1'b1;
        @(negedge CLK);
        start_s[0] = 1'b0;
        repeat (3) @(negedge CLK);
        n_vec++;
        if (valid_s[0] !== 1'b1 || dout_s[0] !== 16'h0002) begin
            n_fail++; $display("FAIL rst_pre: got valid=%b dout=%h expected 1 0002", valid_s[0], dout_s[0]);
        end
        RSTN = 1'b0;
        #1;
        n_vec++;
        if ({en_s[0], rw_s[0], valid_s[0], busy_s[0], last_s[0], done_s[0]} !== 6'b100000 || dout_s[0] !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got en=%b valid=%b busy=%b dout=%h expected 1 0 0 0000",
                     en_s[0], valid_s[0], busy_s[0], dout_s[0]);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        drain(0, 12'h204, 4'b1111, -1, 12'h000);
        n_vec++;
        if (g_dout.size() != 8 || g_ops.size() == 0 || first_valid != 3) begin
            n_fail++; $display("FAIL rst_redrain: got %0d elems valid@%0d expected 8 3", g_dout.size(), first_valid);
        end else if (g_ops[0] !== 5'h00) begin
            n_fail++; $display("FAIL rst_addr0: got %h expected 00", g_ops[0]);
        end
        for (int i = 0; i < g_dout.size(); i++) begin
            n_vec++;
            if (g_dout[i] !== 16'(i + 1)) begin
                n_fail++; $display("FAIL rst_elem[%0d]: got %h expected %h", i, g_dout[i], 16'(i + 1));
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        RSTN = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mnt_s[k] = 12'h0; start_s[k] = 1'b0; ready_s[k] = 1'b1;
            pre_we[k] = 1'b0; pre_addr[k] = 4'd0; pre_data[k] = 64'h0;
        end
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        test_reset();
        test_basic();
        test_padding();
        test_stall();
        test_clear();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/obuf_drain.md
Name: obuf_drain

Overview:
- Reader at the far end of the output-buffer port of the MAC array.
- After a MAC pass completes, walks the output buffer, reads each 64-bit word holding four 16-bit results, and unpacks the valid elements.
- Streams elements to the host side over a valid/ready handshake, in row-major order.
- Can optionally zero each buffer word after reading it, so the buffer is clean for the next pass.

Parameters:
- CLEAR_AFTER_READ, 0, 1 = write 64'h0 back to each word immediately after it is read.
- ELEM_W, 16, width of one result element; four per 64-bit word.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- MNT  in  12  M=[11:8] rows, N=[7:4] (unused), T=[3:0] columns; sampled on accepted START.
- START  in  1  one-cycle pulse to begin a drain.
- EN_O  out  1  output-buffer enable, active-low.
- RW_O  out  1  1 = write, 0 = read.
- ADDR_O  out  4  output-buffer word address.
- WDATA_O  out  64  write data; always 64'h0.
- RDATA_O  in  64  read data, valid the cycle after a read request.
- DOUT  out  16  result element.
- DOUT_VALID  out  1  DOUT holds a valid element.
- DOUT_READY  in  1  sink accepts when DOUT_VALID && DOUT_READY.
- DOUT_ROW  out  3  row index of DOUT (0..M-1).
- DOUT_COL  out  3  column index of DOUT (0..T-1).
- DOUT_LAST  out  1  high with the final element.
- BUSY  out  1  high from the accepted START until DONE.
- DONE  out  1  one-cycle pulse when the drain finishes.
- ERR  out  1  set by an illegal MNT; cleared by the next accepted START.

Behaviour:
- Reset values: EN_O=1, RW_O=0, ADDR_O=0, WDATA_O=0, DOUT=0, DOUT_VALID=0, DOUT_ROW=0, DOUT_COL=0, DOUT_LAST=0, BUSY=0, DONE=0, ERR=0; FSM in IDLE.
- Geometry: WPR = 1 if T<=4, else 2. Word address = row*WPR + w (w = 0..WPR-1); maximum 16 words.
- Word packing: element 0 = [63:48], element 1 = [47:32], element 2 = [31:16], element 3 = [15:0].
- Column mapping: column = w*4 + element index. Columns >= T are padding and are never emitted.
- Legal MNT: 1<=M<=8 and 1<=T<=8.
- Illegal MNT on START: no buffer access; ERR=1 and DONE pulses on the cycle after START; return to IDLE.
- States: IDLE, RD_REQ, RD_CAP, CLR, EMIT, FIN.
- IDLE: START=1 → latch M/T, clear row/w counters and ERR, BUSY=1, go to RD_REQ. START while BUSY is ignored.
- RD_REQ (1 cycle): EN_O=0, RW_O=0, ADDR_O=current address; go to RD_CAP.
- RD_CAP (1 cycle): EN_O=1; capture RDATA_O into a 64-bit holding register; go to CLR if CLEAR_AFTER_READ=1, else EMIT.
- CLR (1 cycle): EN_O=0, RW_O=1, same ADDR_O, WDATA_O=0; go to EMIT.
- EMIT: present elements of the held word in order, one per handshake.
  - DOUT, DOUT_VALID, DOUT_ROW, DOUT_COL and DOUT_LAST are registered and stay stable while VALID && !READY.
  - After the last valid element of a word is accepted: next word → RD_REQ; last word of the matrix → FIN.
  - No element is dropped or duplicated under any READY pattern.
- FIN: DONE=1 for one cycle, BUSY=0, DOUT_VALID=0; go to IDLE.
- Latency with READY held high and CLEAR_AFTER_READ=0:
  - START at cycle 0, read request at cycle 1, first DOUT_VALID at cycle 3.
  - Each word costs 2 + (elements in word) cycles; CLEAR_AFTER_READ adds 1 cycle per word.
- Buffer access: EN_O is low only in RD_REQ and CLR. Outside those states RW_O=0.
- DOUT_LAST: high only on element (M-1, T-1).
- Reset mid-operation: all outputs return to reset values immediately. A partially cleared buffer is left as-is.

Test Plan:
- M=2, T=4, no clear, READY=1; words 0,1 preloaded with 0x0001_0002_0003_0004 and 0x0005_0006_0007_0008 → DOUT 1..8; reads at addr 0 then 1; first VALID at cycle 3; LAST on 8; DONE at the end.
- M=1, T=6; word0=0x000A_000B_000C_000D, word1=0x000E_000F_1111_2222 → DOUT A,B,C,D,E,F with COL 0..5; 0x1111 and 0x2222 are never emitted.
- M=8, T=8, READY toggling 1-0-0-1 → 64 elements in row-major order, 16 reads at addresses 0..15, DOUT held stable during every stall.
- CLEAR_AFTER_READ=1, M=2, T=2 → read then write-zero (RW_O=1, WDATA_O=0) at addr 0, then addr 1; a follow-up drain returns all zeros.
- MNT=12'h040 (M=0) → ERR=1 and DONE one cycle after START; EN_O stays 1; a START while BUSY in a legal drain is ignored.
- RSTN pulled low in EMIT mid-word → EN_O=1, DOUT_VALID=0, BUSY=0 immediately; after release, a new START drains normally from address 0.
